instr_fetch_unit: RTL and testbench

//  Fetch-side initiator for the 8-bit instruction memory: drives the IM address bus, waits the memory

---
 rtl/instr_fetch_unit_pkg.sv | 22 ++
 rtl/instr_fetch_unit_fifo.sv | 65 ++++++
 rtl/instr_fetch_unit.sv | 104 ++++++++++
 tb/tb_instr_fetch_unit.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared widths, FSM encodings and the prefetch entry layout for the instruction fetch unit.
package instr_fetch_unit_pkg;

    localparam int unsigned IF_ADDR_W_M1   = 7;
    localparam int unsigned IF_DATA_W_M1   = 7;
    localparam int unsigned IF_ADDR_W      = IF_ADDR_W_M1 + 1;
    localparam int unsigned IF_DATA_W      = IF_DATA_W_M1 + 1;
    localparam int unsigned IM_WAIT_CYCLES = 2;
    localparam int unsigned PF_DEPTH       = 2;

    localparam logic [IF_ADDR_W-1:0] RESET_PC = 8'h00;
    localparam logic [IF_DATA_W-1:0] IF_NOP   = 8'h00;

    localparam logic IF_ST_WAIT  = 1'b0;
    localparam logic IF_ST_PAUSE = 1'b1;

    typedef struct packed {
        logic [IF_ADDR_W-1:0] pc;
        logic [IF_DATA_W-1:0] instr;
    } pf_entry_t;

endpackage

// File: rtl/instr_fetch_unit_fifo.sv
// Prefetch FIFO of {pc, instr} entries with push/pop/flush; flush wins over everything else.
module instr_fetch_unit_fifo
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = PF_DEPTH
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  pf_entry_t                  wdata_i,
    output pf_entry_t                  head_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    pf_entry_t          mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               do_push, do_pop;

    always_comb begin
        do_pop   = pop_i && (count_q != '0);
        do_push  = push_i && ((count_q < CNT_W'(DEPTH)) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is never read while empty, so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch initiator: holds the IM address for a settle time, captures the byte into the prefetch buffer,
// and serves decode over valid/ready with branch redirect and pause.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RST,
    output logic [IF_ADDR_W-1:0] ABUS,
    input  logic [IF_DATA_W-1:0] DATABUS,
    input  logic                 FETCH_EN,
    input  logic                 BR_TAKEN,
    input  logic [IF_ADDR_W-1:0] BR_TARGET,
    output logic                 INSTR_VALID,
    input  logic                 INSTR_READY,
    output logic [IF_DATA_W-1:0] INSTR,
    output logic [IF_ADDR_W-1:0] INSTR_PC
);

    localparam int unsigned WCNT_W  = $clog2(IM_WAIT_CYCLES + 1);
    localparam int unsigned OCC_W   = $clog2(PF_DEPTH) + 1;

    logic                 state_q, state_d;
    logic [WCNT_W-1:0]    cnt_q, cnt_d;
    logic [IF_ADDR_W-1:0] pc_q, pc_d;

    logic                 push, pop, flush, capture, fifo_empty;
    logic [OCC_W-1:0]     occ, occ_after_pop, occ_post;
    pf_entry_t            head, wdata;

    assign pop           = INSTR_VALID && INSTR_READY;
    assign capture       = (state_q == IF_ST_WAIT) && (cnt_q == WCNT_W'(IM_WAIT_CYCLES - 1));
    assign occ_after_pop = occ - OCC_W'(pop);
    assign occ_post      = occ_after_pop + OCC_W'(capture);
    assign wdata         = '{pc: pc_q, instr: DATABUS};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        push    = 1'b0;
        flush   = 1'b0;
        if (BR_TAKEN) begin
            flush   = 1'b1;
            pc_d    = BR_TARGET;
            cnt_d   = '0;
            state_d = FETCH_EN ? IF_ST_WAIT : IF_ST_PAUSE;
        end else begin
            case (state_q)
                IF_ST_WAIT: begin
                    if (capture) begin
                        push    = 1'b1;
                        pc_d    = pc_q + IF_ADDR_W'(1);
                        cnt_d   = '0;
                        state_d = (FETCH_EN && (occ_post < OCC_W'(PF_DEPTH))) ? IF_ST_WAIT : IF_ST_PAUSE;
                    end else if (!FETCH_EN) begin
                        // Abandon the in-flight fetch; the same address is refetched from scratch.
                        cnt_d   = '0;
                        state_d = IF_ST_PAUSE;
                    end else begin
                        cnt_d   = cnt_q + WCNT_W'(1);
                    end
                end
                default: begin
                    if (FETCH_EN && (occ_after_pop < OCC_W'(PF_DEPTH))) begin
                        cnt_d   = '0;
                        state_d = IF_ST_WAIT;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IF_ST_WAIT;
            cnt_q   <= '0;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
        end
    end

    instr_fetch_unit_fifo #(
        .DEPTH (PF_DEPTH)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_i   (RST),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .wdata_i (wdata),
        .head_o  (head),
        .empty_o (fifo_empty),
        .count_o (occ)
    );

    assign ABUS        = pc_q;
    assign INSTR_VALID = !fifo_empty;
    assign INSTR       = fifo_empty ? IF_NOP : head.instr;
    assign INSTR_PC    = fifo_empty ? '0 : head.pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a 10-unit-delay IM holding IM[n] = n ^ 8'hA5.
module tb_instr_fetch_unit;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] ABUS;
    logic [7:0] DATABUS;
    logic       FETCH_EN;
    logic       BR_TAKEN;
    logic [7:0] BR_TARGET;
    logic       INSTR_VALID;
    logic       INSTR_READY;
    logic [7:0] INSTR;
    logic [7:0] INSTR_PC;

    int n_checks = 0;
    int n_errors = 0;

    always #5 CLK = ~CLK;

    assign #10 DATABUS = ABUS ^ 8'hA5;

    instr_fetch_unit dut (
        .CLK         (CLK),
        .RST         (RST),
        .ABUS        (ABUS),
        .DATABUS     (DATABUS),
        .FETCH_EN    (FETCH_EN),
        .BR_TAKEN    (BR_TAKEN),
        .BR_TARGET   (BR_TARGET),
        .INSTR_VALID (INSTR_VALID),
        .INSTR_READY (INSTR_READY),
        .INSTR       (INSTR),
        .INSTR_PC    (INSTR_PC)
    );

    task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
    endtask

    // Wait (bounded) for the next delivered instruction and check it, then let the edge consume it.
    task automatic expect_next(input string tag, input logic [7:0] pc);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (INSTR_VALID) begin
                seen = 1'b1;
                check_eq({tag, "_pc"},    16'(INSTR_PC), 16'(pc));
                check_eq({tag, "_instr"}, 16'(INSTR),    16'(pc ^ 8'hA5));
            end
            tick();
        end
        if (!seen) check_eq({tag, "_timeout"}, 16'd0, 16'd1);
    endtask

    initial begin
        RST         = 1'b1;
        FETCH_EN    = 1'b1;
        BR_TAKEN    = 1'b0;
        BR_TARGET   = 8'h00;
        INSTR_READY = 1'b1;

        // Test 1: reset state, first-fetch latency, address stepping
        do_reset();
        check_eq("rst_valid", 16'(INSTR_VALID), 16'd0);
        check_eq("rst_abus",  16'(ABUS),        16'h00);
        check_eq("rst_instr", 16'(INSTR),       16'h00);
        check_eq("rst_pc",    16'(INSTR_PC),    16'h00);
        tick();
        check_eq("t1_e1_valid", 16'(INSTR_VALID), 16'd0);
        check_eq("t1_e1_abus",  16'(ABUS),        16'h00);
        tick();
        check_eq("t1_e2_valid", 16'(INSTR_VALID), 16'd1);
        check_eq("t1_e2_instr", 16'(INSTR),       16'hA5);
        check_eq("t1_e2_pc",    16'(INSTR_PC),    16'h00);
        check_eq("t1_e2_abus",  16'(ABUS),        16'h01);
        tick();
        tick();
        check_eq("t1_e4_abus",  16'(ABUS),        16'h02);
        check_eq("t1_e4_pc",    16'(INSTR_PC),    16'h01);

        // Test 2: backpressure fills the buffer and pauses, then drains in order
        INSTR_READY = 1'b0;
        do_reset();
        for (int i = 0; i < 10; i++) tick();
        check_eq("t2_valid", 16'(INSTR_VALID), 16'd1);
        check_eq("t2_pc",    16'(INSTR_PC),    16'h00);
        check_eq("t2_instr", 16'(INSTR),       16'hA5);
        check_eq("t2_abus",  16'(ABUS),        16'h02);
        check_eq("t2_state", 16'(dut.state_q), 16'd1);
        INSTR_READY = 1'b1;
        expect_next("t2_d0", 8'h00);
        expect_next("t2_d1", 8'h01);
        expect_next("t2_d2", 8'h02);

        // Test 3: redirect on the edge where a capture fills the buffer
        INSTR_READY = 1'b0;
        do_reset();
        tick();
        tick();
        tick();
        BR_TAKEN    = 1'b1;
        BR_TARGET   = 8'h40;
        INSTR_READY = 1'b1;
        tick();
        BR_TAKEN    = 1'b0;
        check_eq("t3_valid", 16'(INSTR_VALID), 16'd0);
        check_eq("t3_abus",  16'(ABUS),        16'h40);
        expect_next("t3_d0", 8'h40);
        expect_next("t3_d1", 8'h41);

        // Test 4: PC wrap-around
        BR_TAKEN  = 1'b1;
        BR_TARGET = 8'hFE;
        tick();
        BR_TAKEN  = 1'b0;
        expect_next("t4_fe", 8'hFE);
        expect_next("t4_ff", 8'hFF);
        expect_next("t4_00", 8'h00);
        expect_next("t4_01", 8'h01);

        // Test 5: pause mid-wait abandons the fetch; resume refetches with full wait
        do_reset();
        tick();
        tick();
        FETCH_EN = 1'b0;
        tick();
        check_eq("t5_p_valid", 16'(INSTR_VALID), 16'd0);
        check_eq("t5_p_abus",  16'(ABUS),        16'h01);
        tick();
        tick();
        tick();
        check_eq("t5_hold_valid", 16'(INSTR_VALID), 16'd0);
        check_eq("t5_hold_abus",  16'(ABUS),        16'h01);
        FETCH_EN = 1'b1;
        tick();
        check_eq("t5_r0_valid", 16'(INSTR_VALID), 16'd0);
        tick();
        check_eq("t5_r1_valid", 16'(INSTR_VALID), 16'd0);
        tick();
        check_eq("t5_r2_valid", 16'(INSTR_VALID), 16'd1);
        check_eq("t5_r2_pc",    16'(INSTR_PC),    16'h01);
        check_eq("t5_r2_instr", 16'(INSTR),       16'hA4);
        check_eq("t5_r2_abus",  16'(ABUS),        16'h02);

        // Test 6: reset pulse with valid data and a fetch in flight
        INSTR_READY = 1'b0;
        do_reset();
        tick();
        tick();
        tick();
        check_eq("t6_pre_valid", 16'(INSTR_VALID), 16'd1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check_eq("t6_valid", 16'(INSTR_VALID), 16'd0);
        check_eq("t6_abus",  16'(ABUS),        16'h00);
        check_eq("t6_instr", 16'(INSTR),       16'h00);
        INSTR_READY = 1'b1;
        tick();
        check_eq("t6_e1_valid", 16'(INSTR_VALID), 16'd0);
        tick();
        check_eq("t6_e2_valid", 16'(INSTR_VALID), 16'd1);
        check_eq("t6_e2_instr", 16'(INSTR),       16'hA5);
        check_eq("t6_e2_pc",    16'(INSTR_PC),    16'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
